time_entry_loader: RTL and testbench

- Keypad-facing front end of the oven timer. Accepts decoded key strobes and shifts BCD digits into an M:SS entry register.
- On START, presents the entry to the cascaded mod-10/mod-6 countdown chain through a one-cycle active-low load pulse, then enables counting.
- Stops counting when the chain reports zero or CLEAR is pressed.
- Sits directly upstream of the counter chain: drives its data, loadn and en inputs, and consumes its zero output.

---
 rtl/time_entry_loader_pkg.sv | 37 +++
 rtl/time_entry_loader_key_edge_detect.sv | 32 +++
 rtl/time_entry_loader.sv | 179 +++++++++++++++++
 tb/tb_time_entry_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_loader_pkg.sv
// Shared types and constants for the oven-timer keypad entry front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package time_entry_loader_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Default sizing of the entry register and the seconds-tens limit.
  localparam int               MAX_DIGITS_DEF   = 3;
  localparam logic [BCD_W-1:0] MAX_SEC_TENS_DEF = 4'd5;

  // Default key codes for the two command keys; 0-9 are digit keys.
  localparam logic [3:0] KEY_CLEAR_DEF = 4'hA;
  localparam logic [3:0] KEY_START_DEF = 4'hB;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // M:SS entry register, most significant digit first.
  typedef struct packed {
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } entry_t;

  // True for the ten digit keys.
  function automatic logic is_digit_code(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/time_entry_loader_key_edge_detect.sv
// Turns the held key_valid level into a single key_event pulse with its code.
// Latency: key_event is combinational in the cycle key_valid first reads high.
// Backpressure: none; a held key yields exactly one event until released.
module key_edge_detect
  import time_entry_loader_pkg::*;
(
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] key_dat
);

  logic key_valid_q;

  // Remember last cycle's key level so a rising edge can be spotted.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
    end
  end

  // Event fires only on the 0->1 transition; the code is taken in that same cycle.
  always_comb begin
    key_event = key_valid & ~key_valid_q;
    key_dat   = key_code;
  end

endmodule

// File: rtl/time_entry_loader.sv
// Keypad front end: shifts BCD digits into M:SS, loads the countdown chain, runs it.
// Latency: every output is registered; a key takes effect on the edge that first sees it.
// Backpressure: none; keys that do not apply in the current state are dropped.
module time_entry_loader
  import time_entry_loader_pkg::*;
#(
  parameter int               MAX_DIGITS   = MAX_DIGITS_DEF,
  parameter logic [BCD_W-1:0] MAX_SEC_TENS = MAX_SEC_TENS_DEF,
  parameter logic [3:0]       KEY_CLEAR    = KEY_CLEAR_DEF,
  parameter logic [3:0]       KEY_START    = KEY_START_DEF
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             zero,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic             loadn,
  output logic             en,
  output logic             err,
  output logic [1:0]       digit_cnt
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  // Key event from the edge detector.
  logic       key_event;
  logic [3:0] key_dat;

  key_edge_detect u_key_edge (
    .clock     (clock),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_event (key_event),
    .key_dat   (key_dat)
  );

  // Decoded key classes, each qualified by the event pulse.
  logic ev_digit;
  logic ev_clear;
  logic ev_start;

  // Sort the event into digit / CLEAR / START; anything else matches none.
  always_comb begin
    ev_digit = key_event & is_digit_code(key_dat);
    ev_clear = key_event & (key_dat == KEY_CLEAR);
    ev_start = key_event & (key_dat == KEY_START);
  end

  // State, entry and output registers.
  state_t     state_q,     state_d;
  entry_t     entry_q,     entry_d;
  logic [1:0] cnt_q,       cnt_d;
  logic       loadn_q,     loadn_d;
  logic       en_q,        en_d;
  logic       err_q,       err_d;
  // High only in the first RUN cycle, while the chain is still settling from the load.
  logic       run_first_q, run_first_d;

  // START is accepted only for a legal, non-empty time.
  logic start_ok;

  // Judge the current entry: seconds-tens in range and not 0:00.
  always_comb begin
    start_ok = (entry_q.sec_tens <= MAX_SEC_TENS) && (entry_q != '0);
  end

  // Next-state, entry update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    run_first_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // First digit starts a fresh entry; command keys do nothing here.
        if (ev_digit) begin
          entry_d          = '0;
          entry_d.sec_ones = key_dat;
          cnt_d            = 2'd1;
          state_d          = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (ev_digit) begin
          // Shift left while room remains; a digit past the limit is dropped.
          if (cnt_q < MAX_CNT) begin
            entry_d.min_ones = entry_q.sec_tens;
            entry_d.sec_tens = entry_q.sec_ones;
            entry_d.sec_ones = key_dat;
            cnt_d            = cnt_q + 2'd1;
          end
        end else if (ev_clear) begin
          entry_d = '0;
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (ev_start) begin
          if (start_ok) begin
            state_d = ST_LOAD;
          end else begin
            // Illegal time: flag it for one cycle and throw the entry away.
            err_d   = 1'b1;
            entry_d = '0;
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_LOAD: begin
        // Single-cycle load strobe; the chain captures the digits on this edge.
        state_d     = ST_RUN;
        run_first_d = 1'b1;
      end

      ST_RUN: begin
        // CLEAR wins over zero; zero is not trusted in the first RUN cycle.
        if (ev_clear) begin
          entry_d = '0;
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (zero && !run_first_q) begin
          entry_d = '0;
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        entry_d = '0;
        cnt_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Strobes follow the state being entered, so they line up with it exactly.
    loadn_d = (state_d != ST_LOAD);
    en_d    = (state_d == ST_RUN);
  end

  // Register everything; reset forces the chain idle (loadn high, en low) at once.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      cnt_q       <= 2'd0;
      loadn_q     <= 1'b1;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
      run_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      loadn_q     <= loadn_d;
      en_q        <= en_d;
      err_q       <= err_d;
      run_first_q <= run_first_d;
    end
  end

  // Drive the chain and status outputs straight from registers.
  always_comb begin
    min_ones  = entry_q.min_ones;
    sec_tens  = entry_q.sec_tens;
    sec_ones  = entry_q.sec_ones;
    digit_cnt = cnt_q;
    loadn     = loadn_q;
    en        = en_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_time_entry_loader.sv
// Self-checking bench for time_entry_loader: vector table, corner sequences, random run.
// Latency: outputs compared 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_time_entry_loader;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       zero = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       loadn, en, err;
  logic [1:0] digit_cnt;

  time_entry_loader dut (
    .clock     (clock),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .zero      (zero),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .loadn     (loadn),
    .en        (en),
    .err       (err),
    .digit_cnt (digit_cnt)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the entry is the list of typed digits (oldest first);
  // phase 0 = editing/idle, 1 = load strobe, 2 = counting.
  int mq[$];
  int m_phase;
  int m_age;
  bit m_prev;
  bit m_err;

  function automatic void m_reset();
    mq.delete();
    m_phase = 0;
    m_age   = 0;
    m_prev  = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic int m_digit(input int pos);
    int idx;
    idx = mq.size() - 1 - pos;
    return (idx >= 0) ? mq[idx] : 0;
  endfunction

  function automatic void m_step(input bit kv, input int kc, input bit z);
    bit ev;
    int tens;
    int total;
    ev     = kv && !m_prev;
    m_prev = kv;
    m_err  = 1'b0;
    if (m_phase == 0) begin
      if (ev) begin
        if (kc <= 9) begin
          if (mq.size() < 3) mq.push_back(kc);
        end else if (kc == 10) begin
          mq.delete();
        end else if (kc == 11 && mq.size() > 0) begin
          tens  = m_digit(1);
          total = m_digit(0) + m_digit(1) + m_digit(2);
          if (tens <= 5 && total > 0) m_phase = 1;
          else begin
            m_err = 1'b1;
            mq.delete();
          end
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_age   = 0;
    end else begin
      if (ev && kc == 10) begin
        mq.delete();
        m_phase = 0;
      end else if (m_age > 0 && z) begin
        mq.delete();
        m_phase = 0;
      end else begin
        m_age++;
      end
    end
  endfunction

  task automatic check_model();
    logic [16:0] e, a;
    e = {4'(m_digit(2)), 4'(m_digit(1)), 4'(m_digit(0)), 2'(mq.size()),
         (m_phase != 1), (m_phase == 2), m_err};
    a = {min_ones, sec_tens, sec_ones, digit_cnt, loadn, en, err};
    chk("cycle", 32'(a), 32'(e));
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge, compare after.
  task automatic cyc(input bit kv, input logic [3:0] kc, input bit z);
    @(negedge clock);
    key_valid = kv;
    key_code  = kc;
    zero      = z;
    @(posedge clock);
    m_step(kv, int'(kc), z);
    #1;
    check_model();
  endtask

  task automatic press(input logic [3:0] kc, input int hold);
    repeat (hold) cyc(1'b1, kc, 1'b0);
    cyc(1'b0, kc, 1'b0);
  endtask

  task automatic do_reset(input bit check_it);
    @(negedge clock);
    clrn      = 1'b0;
    key_valid = 1'b0;
    zero      = 1'b0;
    m_reset();
    #1;
    if (check_it) begin
      chk("rst_digits", 32'({min_ones, sec_tens, sec_ones}), 32'd0);
      chk("rst_cnt",    32'(digit_cnt), 32'd0);
      chk("rst_strobes", 32'({loadn, en, err}), 32'b100);
    end
    @(negedge clock);
    clrn = 1'b1;
  endtask

  typedef struct {
    int          n;
    logic [23:0] keys;   // first key in the top nibble
    int          hold;
    logic [3:0]  em, et, eo;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3, 24'h130000, 1, 4'd1, 4'd3, 4'd0, 2'd3};
    tbl[1] = '{2, 24'h240000, 5, 4'd0, 4'd2, 4'd4, 2'd2};
    tbl[2] = '{4, 24'h123400, 1, 4'd1, 4'd2, 4'd3, 2'd3};
    tbl[3] = '{4, 24'h170B00, 1, 4'd0, 4'd0, 4'd0, 2'd0};
    tbl[4] = '{3, 24'h5A9000, 2, 4'd0, 4'd0, 4'd9, 2'd1};
    tbl[5] = '{3, 24'hCF7000, 1, 4'd0, 4'd0, 4'd7, 2'd1};
    tbl[6] = '{2, 24'hBA0000, 1, 4'd0, 4'd0, 4'd0, 2'd0};
    tbl[7] = '{5, 24'h12A340, 3, 4'd0, 4'd3, 4'd4, 2'd2};

    do_reset(1'b1);

    // Table of key sequences with their final entry state.
    for (int v = 0; v < 8; v++) begin
      logic [23:0] ks;
      do_reset(1'b0);
      ks = tbl[v].keys;
      for (int k = 0; k < tbl[v].n; k++) press(ks[23-4*k -: 4], tbl[v].hold);
      chk($sformatf("vec%0d_min", v), 32'(min_ones), 32'(tbl[v].em));
      chk($sformatf("vec%0d_tens", v), 32'(sec_tens), 32'(tbl[v].et));
      chk($sformatf("vec%0d_ones", v), 32'(sec_ones), 32'(tbl[v].eo));
      chk($sformatf("vec%0d_cnt", v), 32'(digit_cnt), 32'(tbl[v].ec));
    end

    // 1:30 START: one-cycle load strobe, then counting holds while zero stays low.
    do_reset(1'b0);
    press(4'd1, 1); press(4'd3, 1); press(4'd0, 1);
    cyc(1'b1, 4'hB, 1'b0);
    chk("load_loadn", 32'(loadn), 32'd0);
    chk("load_en", 32'(en), 32'd0);
    chk("load_digits", 32'({min_ones, sec_tens, sec_ones}), 32'h130);
    cyc(1'b0, 4'hB, 1'b0);
    chk("run_loadn", 32'(loadn), 32'd1);
    chk("run_en", 32'(en), 32'd1);
    repeat (3) cyc(1'b0, 4'd0, 1'b0);
    chk("run_hold_en", 32'(en), 32'd1);
    chk("run_hold_digits", 32'({min_ones, sec_tens, sec_ones}), 32'h130);

    // 1:70 START is illegal: err pulses once, no load, back to idle.
    do_reset(1'b0);
    press(4'd1, 1); press(4'd7, 1); press(4'd0, 1);
    cyc(1'b1, 4'hB, 1'b0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_loadn", 32'(loadn), 32'd1);
    cyc(1'b0, 4'hB, 1'b0);
    chk("bad_err_drop", 32'(err), 32'd0);
    chk("bad_digits", 32'({min_ones, sec_tens, sec_ones}), 32'h000);
    press(4'd3, 1);
    chk("bad_idle_cnt", 32'(digit_cnt), 32'd1);

    // 0:05: zero in the first RUN cycle is ignored, later zero stops the run.
    do_reset(1'b0);
    press(4'd0, 1); press(4'd5, 1);
    cyc(1'b1, 4'hB, 1'b0);
    cyc(1'b0, 4'hB, 1'b0);
    cyc(1'b0, 4'd0, 1'b1);
    chk("zero_early_en", 32'(en), 32'd1);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1);
    chk("zero_stop_en", 32'(en), 32'd0);
    chk("zero_stop_digits", 32'({min_ones, sec_tens, sec_ones}), 32'h000);
    chk("zero_stop_cnt", 32'(digit_cnt), 32'd0);

    // CLEAR together with zero, then asynchronous reset during LOAD.
    do_reset(1'b0);
    press(4'd1, 1); press(4'd0, 1); press(4'd0, 1);
    cyc(1'b1, 4'hB, 1'b0);
    cyc(1'b0, 4'hB, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'hA, 1'b1);
    chk("clr_en", 32'(en), 32'd0);
    chk("clr_digits", 32'({min_ones, sec_tens, sec_ones}), 32'h000);
    cyc(1'b0, 4'hA, 1'b0);
    press(4'd2, 1);
    chk("clr_idle_ones", 32'(sec_ones), 32'd2);
    chk("clr_idle_cnt", 32'(digit_cnt), 32'd1);
    cyc(1'b1, 4'hB, 1'b0);
    chk("arst_pre_loadn", 32'(loadn), 32'd0);
    clrn      = 1'b0;
    key_valid = 1'b0;
    #1;
    chk("arst_loadn", 32'(loadn), 32'd1);
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_digits", 32'({min_ones, sec_tens, sec_ones}), 32'h000);
    m_reset();
    @(negedge clock);
    clrn = 1'b1;

    // Random key traffic and zero pulses against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      int hold;
      int rel;
      logic [3:0] kc;
      r = int'($urandom_range(0, 99));
      if (r < 60)      kc = 4'($urandom_range(0, 9));
      else if (r < 75) kc = 4'hB;
      else if (r < 85) kc = 4'hA;
      else             kc = 4'($urandom_range(12, 15));
      hold = int'($urandom_range(1, 4));
      rel  = int'($urandom_range(1, 3));
      repeat (hold) cyc(1'b1, kc, ($urandom_range(0, 7) == 0));
      repeat (rel)  cyc(1'b0, kc, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 99) == 0) do_reset(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
